led_pattern_sequencer: RTL and testbench

- Upstream pattern source for the iCEstick LED outputs D1..D5. D1–D4 are the red ring LEDs; D5 is the green centre LED.
- Generates one of four animated patterns, stepped by a prescaled tick.
- Applies global PWM brightness to the pattern and drives five registered LED lines, which go straight to the board pins.
- Mode 0 reproduces the static "all LEDs on" image.

---
 rtl/led_pattern_sequencer.sv | 103 ++++++++++
 tb/tb_led_pattern_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// Animated pattern source for the iCEstick D1..D5 LEDs.
// Prescaled pattern stepping, synchronised mode select and global PWM dimming.
module led_pattern_sequencer #(
  parameter int STEP_DIV = 3000000,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] bright,
  output logic                d1,
  output logic                d2,
  output logic                d3,
  output logic                d4,
  output logic                d5,
  output logic                step
);

  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] DLAST = DW'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] PMAX = '1;

  typedef enum logic {UP, DOWN} dir_t;

  logic [DW-1:0]       div_cnt;
  logic                tick;
  logic [1:0]          mode_m;
  logic [1:0]          mode_s;
  logic [1:0]          mode_act;
  logic [1:0]          act_nx;
  logic [4:0]          pat;
  logic [4:0]          pat_nx;
  dir_t                dir;
  dir_t                dir_nx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] bright_q;
  logic                en;

  assign tick = (div_cnt == DLAST);
  assign en   = (bright_q == PMAX) || (pwm_cnt < bright_q);

  // Mode switches are only honoured on a step tick; otherwise the pattern advances.
  always_comb begin
    pat_nx = pat;
    dir_nx = dir;
    act_nx = mode_act;
    if (tick) begin
      if (mode_s != mode_act) begin
        act_nx = mode_s;
        dir_nx = UP;
        unique case (mode_s)
          2'd0: pat_nx = 5'b11111;
          2'd1: pat_nx = 5'b00001;
          2'd2: pat_nx = 5'b00000;
          2'd3: pat_nx = 5'b10001;
        endcase
      end else begin
        unique case (mode_act)
          2'd0: pat_nx = 5'b11111;
          2'd1: begin
            if (dir == UP) begin
              pat_nx = pat << 1;
              if (pat_nx == 5'b10000) dir_nx = DOWN;
            end else begin
              pat_nx = pat >> 1;
              if (pat_nx == 5'b00001) dir_nx = UP;
            end
          end
          2'd2: pat_nx = pat + 5'd1;
          2'd3: pat_nx = {~pat[4], pat[2:0], pat[3]};
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      step     <= 1'b0;
      mode_m   <= 2'd0;
      mode_s   <= 2'd0;
      mode_act <= 2'd0;
      pat      <= 5'b11111;
      dir      <= UP;
      pwm_cnt  <= '0;
      bright_q <= '0;
      {d5, d4, d3, d2, d1} <= 5'b00000;
    end else begin
      div_cnt  <= tick ? '0 : div_cnt + 1'b1;
      step     <= tick;
      mode_m   <= mode;
      mode_s   <= mode_m;
      mode_act <= act_nx;
      pat      <= pat_nx;
      dir      <= dir_nx;
      pwm_cnt  <= pwm_cnt + 1'b1;
      // Latch brightness only at the end of a PWM period.
      if (pwm_cnt == PMAX) bright_q <= bright;
      {d5, d4, d3, d2, d1} <= pat & {5{en}};
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised and directed bench for led_pattern_sequencer.
// Reference model tracks mode and step index, derives patterns from tables.
module tb_led_pattern_sequencer;

  localparam int SD = 4;
  localparam int PB = 2;
  localparam int P  = 1 << PB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [PB-1:0] bright = '0;
  logic          d1, d2, d3, d4, d5, step;

  led_pattern_sequencer #(
    .STEP_DIV(SD),
    .PWM_BITS(PB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .bright(bright),
    .d1(d1),
    .d2(d2),
    .d3(d3),
    .d4(d4),
    .d5(d5),
    .step(step)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state: cycles since reset, synchroniser taps, active mode,
  // advances since the last load, captured brightness, expected outputs.
  int            c;
  int            act;
  int            k;
  logic [1:0]    m1, m2;
  int            bq;
  logic [4:0]    exp_d;
  logic          exp_step;
  logic [4:0]    scan_tbl [8] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd8, 5'd4, 5'd2};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] pat_of(input int a, input int n);
    logic [4:0] p;
    p = 5'd0;
    case (a)
      0: p = 5'b11111;
      1: p = scan_tbl[n % 8];
      2: p = 5'(n % 32);
      default: p = 5'((1 << (n % 4)) | (((n % 2) == 0) ? 16 : 0));
    endcase
    return p;
  endfunction

  task automatic model_edge();
    bit tick;
    bit en;
    if (rst) begin
      c = 0; act = 0; k = 0; m1 = 2'd0; m2 = 2'd0; bq = 0;
      exp_d = 5'd0; exp_step = 1'b0;
    end else begin
      tick = ((c % SD) == SD - 1);
      en = (bq == P - 1) || ((c % P) < bq);
      exp_d = en ? pat_of(act, k) : 5'd0;
      exp_step = tick;
      if (tick) begin
        if (int'(m2) != act) begin
          act = int'(m2);
          k = 0;
        end else begin
          k++;
        end
      end
      if ((c % P) == P - 1) bq = int'(bright);
      m2 = m1;
      m1 = mode;
      c++;
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] m,
                     input logic [PB-1:0] b);
    rst = r;
    mode = m;
    bright = b;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("d", {27'd0, d5, d4, d3, d2, d1}, {27'd0, exp_d});
    check("step", {31'd0, step}, {31'd0, exp_step});
  endtask

  int lit;

  initial begin
    // Reset and default image
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd0, 2'd3);
    for (int i = 0; i < 16; i++) cyc(1'b0, 2'd0, 2'd3);

    // Scan bounce, count wrap, ring
    for (int i = 0; i < 48; i++) cyc(1'b0, 2'd1, 2'd3);
    for (int i = 0; i < 140; i++) cyc(1'b0, 2'd2, 2'd3);
    for (int i = 0; i < 28; i++) cyc(1'b0, 2'd3, 2'd3);

    // Duty cycle at three brightness levels
    for (int i = 0; i < 12; i++) cyc(1'b0, 2'd0, 2'd1);
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 2'd0, 2'd1);
      if ({d5, d4, d3, d2, d1} == 5'b11111) lit++;
    end
    check("duty1", 32'(lit), 32'd4);
    for (int i = 0; i < 8; i++) cyc(1'b0, 2'd0, 2'd0);
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 2'd0, 2'd0);
      if ({d5, d4, d3, d2, d1} != 5'b00000) lit++;
    end
    check("duty0", 32'(lit), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 2'd0, 2'd3);
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 2'd0, 2'd3);
      if ({d5, d4, d3, d2, d1} == 5'b11111) lit++;
    end
    check("duty3", 32'(lit), 32'd16);
    // Brightness change in the middle of a PWM period
    cyc(1'b0, 2'd0, 2'd3);
    for (int i = 0; i < 10; i++) cyc(1'b0, 2'd0, 2'd1);

    // Mode change shortly before a tick, then a bounce back
    for (int i = 0; i < 21; i++) cyc(1'b0, 2'd1, 2'd3);
    for (int i = 0; i < 14; i++) cyc(1'b0, 2'd2, 2'd3);
    cyc(1'b0, 2'd3, 2'd3);
    for (int i = 0; i < 10; i++) cyc(1'b0, 2'd2, 2'd3);

    // Reset in the middle of a scan step
    for (int i = 0; i < 18; i++) cyc(1'b0, 2'd1, 2'd3);
    cyc(1'b1, 2'd1, 2'd3);
    check("rst_mid", {27'd0, d5, d4, d3, d2, d1}, 32'd0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 2'd1, 2'd3);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [1:0] m;
      logic [PB-1:0] b;
      logic r;
      m = mode;
      b = bright;
      if ($urandom_range(0, 19) == 0) m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 14) == 0) b = PB'($urandom_range(0, P - 1));
      r = ($urandom_range(0, 149) == 0);
      cyc(r, m, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
